// File: rtl/l2_flatten.sv
// l2_flatten: copies the two 32x32 layer-1 max-pool maps into layer-2 memory,
// interleaving them word by word (L2[2i] = K0[i], L2[2i+1] = K1[i]).
// Every read and every write uses its own cycle on the shared csel/crd/cwr bus.
// Bus handshake: the memory has no ready. crd=1 for exactly one cycle with
// csel/caddr_rd stable, and cdata_rd is taken RD_LAT cycles later. cwr=1 for
// exactly one cycle with csel/caddr_wr/cdata_wr stable, and the write is
// accepted in that cycle.
module l2_flatten #(
    parameter int DATA_W   = 20,
    parameter int ADDR_W   = 12,
    parameter int L1_WORDS = 1024,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_rd,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic              cwr,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [DATA_W-1:0] cdata_wr,
    output logic [2:0]        csel,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_CAP  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [2:0]        SEL_NONE = 3'b000;
    localparam logic [2:0]        SEL_K0   = 3'b011;
    localparam logic [2:0]        SEL_K1   = 3'b100;
    localparam logic [2:0]        SEL_L2   = 3'b101;
    // Index of the last output word; stopping here keeps j from wrapping.
    localparam logic [ADDR_W-1:0] LAST_J   = ADDR_W'(2 * L1_WORDS - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   j_q;
    logic [ADDR_W-1:0]   j_d;
    logic                busy_q;
    logic                done_q;
    logic                crd_q;
    logic                cwr_q;
    logic [ADDR_W-1:0]   caddr_rd_q;
    logic [ADDR_W-1:0]   caddr_wr_q;
    logic [DATA_W-1:0]   cdata_wr_q;
    logic [2:0]          csel_q;

    // Next output index; only committed when another word follows.
    assign j_d = j_q + 1'b1;

    // Sequencer: every output is loaded on the edge entering the state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            j_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
            csel_q     <= SEL_NONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_RD;
                        j_q        <= '0;
                        busy_q     <= 1'b1;
                        crd_q      <= 1'b1;
                        csel_q     <= SEL_K0;
                        caddr_rd_q <= '0;
                    end
                end
                S_RD: begin
                    // csel stays on the source map until the data is captured.
                    crd_q   <= 1'b0;
                    state_q <= (RD_LAT == 2) ? S_WAIT : S_CAP;
                end
                S_WAIT: begin
                    state_q <= S_CAP;
                end
                S_CAP: begin
                    cdata_wr_q <= cdata_rd;
                    cwr_q      <= 1'b1;
                    csel_q     <= SEL_L2;
                    caddr_wr_q <= j_q;
                    state_q    <= S_WR;
                end
                S_WR: begin
                    cwr_q <= 1'b0;
                    if (j_q == LAST_J) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        csel_q  <= SEL_NONE;
                    end else begin
                        // Even outputs come from kernel 0, odd from kernel 1.
                        j_q        <= j_d;
                        state_q    <= S_RD;
                        crd_q      <= 1'b1;
                        csel_q     <= j_d[0] ? SEL_K1 : SEL_K0;
                        caddr_rd_q <= j_d >> 1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign crd       = crd_q;
    assign cwr       = cwr_q;
    assign caddr_rd  = caddr_rd_q;
    assign caddr_wr  = caddr_wr_q;
    assign cdata_wr  = cdata_wr_q;
    assign csel      = csel_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_l2_flatten.sv
// Directed bench for l2_flatten: instance 0 uses RD_LAT=1, instance 1 RD_LAT=2.
// Both share the layer-1 memory model; each has its own layer-2 image.
module tb_l2_flatten;

    logic             clk;
    logic             reset;
    logic [1:0]       start;
    logic [1:0]       busy;
    logic [1:0]       done;
    logic [1:0]       crd;
    logic [1:0]       cwr;
    logic [1:0][11:0] caddr_rd;
    logic [1:0][11:0] caddr_wr;
    logic [1:0][19:0] cdata_rd;
    logic [1:0][19:0] cdata_wr;
    logic [1:0][2:0]  csel;
    logic [1:0][2:0]  state_dbg;

    logic [19:0] l1k0 [1024];
    logic [19:0] l1k1 [1024];
    logic [19:0] l2_mem [2][2048];

    int n_checks;
    int n_fail;

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [19:0] s1_q;
        logic [19:0] s2_q;

        l2_flatten #(.RD_LAT(g + 1)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .crd       (crd[g]),
            .caddr_rd  (caddr_rd[g]),
            .cdata_rd  (cdata_rd[g]),
            .cwr       (cwr[g]),
            .caddr_wr  (caddr_wr[g]),
            .cdata_wr  (cdata_wr[g]),
            .csel      (csel[g]),
            .state_dbg (state_dbg[g])
        );

        // synchronous read memory, optional extra output register
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_q <= '0;
                s2_q <= '0;
            end else begin
                if (crd[g]) begin
                    if (csel[g] == 3'b011)      s1_q <= l1k0[caddr_rd[g][9:0]];
                    else if (csel[g] == 3'b100) s1_q <= l1k1[caddr_rd[g][9:0]];
                    else                        s1_q <= 20'h0BAD0;
                end
                s2_q <= s1_q;
            end
        end

        if (g == 0) begin : g_lat1
            assign cdata_rd[g] = s1_q;
        end else begin : g_lat2
            assign cdata_rd[g] = s2_q;
        end
    end

    // pattern 0: K0[i]=i, K1[i]=80000|i ; pattern 1: K0 all ones, K1 all zeros
    task automatic load_data(input int pat);
        for (int i = 0; i < 1024; i++) begin
            if (pat == 0) begin
                l1k0[i] = 20'(i);
                l1k1[i] = 20'h80000 | 20'(i);
            end else begin
                l1k0[i] = 20'hFFFFF;
                l1k1[i] = 20'h00000;
            end
        end
    endtask

    function automatic logic [19:0] exp_l2(input int pat, input int a);
        if (pat == 0) return (a % 2 == 0) ? 20'(a / 2) : (20'h80000 | 20'(a / 2));
        return (a % 2 == 0) ? 20'hFFFFF : 20'h00000;
    endfunction

    function automatic int bad_words(input int k, input int pat);
        int n = 0;
        for (int a = 0; a < 2048; a++)
            if (l2_mem[k][a] !== exp_l2(pat, a)) n++;
        return n;
    endfunction

    // Drives one start (cycle 0) plus optional extra start pulses and watches
    // ncyc cycles, tallying writes, done pulses and protocol/timing errors.
    task automatic run_flat(input int k, input int p1, input int p2, input int p3,
                            input int ncyc, output int nwr, output int done_cyc,
                            output int ndone, output int busy_bad, output int proto_bad);
        int   t_run = 2048 * (k + 3);
        int   run_s = 0;
        int   rd_n  = 0;
        int   wr_n  = 0;
        logic exp_busy;
        logic exp_done;
        logic idle_c;
        nwr = 0; done_cyc = -1; ndone = 0; busy_bad = 0; proto_bad = 0;
        for (int a = 0; a < 2048; a++) l2_mem[k][a] = 'x;
        @(negedge clk);
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            idle_c   = !(c >= run_s + 1 && c <= run_s + t_run + 1);
            start[k] = (c == p1 || c == p2 || c == p3);
            @(negedge clk);
            exp_busy = (c >= run_s + 1 && c <= run_s + t_run);
            exp_done = (c == run_s + t_run + 1);
            if (busy[k] !== exp_busy || done[k] !== exp_done) busy_bad++;
            if (done[k] === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (crd[k] === 1'b1 && cwr[k] === 1'b1) proto_bad++;
            if (crd[k] === 1'b1) begin
                if (csel[k] !== ((rd_n % 2 == 1) ? 3'b100 : 3'b011) ||
                    caddr_rd[k] !== 12'((rd_n % 2048) / 2)) proto_bad++;
                rd_n++;
            end
            if (cwr[k] === 1'b1) begin
                if (csel[k] !== 3'b101 || caddr_wr[k] !== 12'(wr_n % 2048)) proto_bad++;
                if (caddr_wr[k] < 12'd2048) l2_mem[k][caddr_wr[k][10:0]] = cdata_wr[k];
                else proto_bad++;
                wr_n++;
                nwr++;
            end
            if (start[k] && idle_c) run_s = c;
            @(posedge clk);
            #1;
        end
        start[k] = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({busy[k], done[k], crd[k], cwr[k], csel[k], caddr_rd[k], caddr_wr[k], cdata_wr[k]} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got busy=%b done=%b crd=%b cwr=%b csel=%b, required all zero",
                         k, busy[k], done[k], crd[k], cwr[k], csel[k]);
            end
            n_checks++;
            if (state_dbg[k] !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got %0d required 0", k, state_dbg[k]);
            end
        end
    endtask

    task automatic check_run(input string name, input int k, input int pat,
                             input int nwr, input int exp_nwr,
                             input int busy_bad, input int proto_bad);
        int bw;
        n_checks++;
        if (nwr != exp_nwr) begin
            n_fail++;
            $display("FAIL %s_writes: got %0d required %0d", name, nwr, exp_nwr);
        end
        n_checks++;
        if (busy_bad != 0) begin
            n_fail++;
            $display("FAIL %s_busy_done_timing: got %0d bad cycles required 0", name, busy_bad);
        end
        n_checks++;
        if (proto_bad != 0) begin
            n_fail++;
            $display("FAIL %s_bus_protocol: got %0d violations required 0", name, proto_bad);
        end
        bw = bad_words(k, pat);
        n_checks++;
        if (bw != 0) begin
            n_fail++;
            $display("FAIL %s_l2_contents: got %0d wrong words required 0 (L2[1]=%h want %h)",
                     name, bw, l2_mem[k][1], exp_l2(pat, 1));
        end
    endtask

    task automatic test_basic();
        int nwr, dc, nd, bb, pb;
        load_data(0);
        run_flat(0, -1, -1, -1, 6150, nwr, dc, nd, bb, pb);
        check_run("basic", 0, 0, nwr, 2048, bb, pb);
        n_checks++;
        if (dc != 6145) begin
            n_fail++;
            $display("FAIL basic_done_cycle: got %0d required 6145", dc);
        end
        n_checks++;
        if (nd != 1) begin
            n_fail++;
            $display("FAIL basic_done_pulses: got %0d required 1", nd);
        end
    endtask

    task automatic test_extreme();
        int nwr, dc, nd, bb, pb;
        load_data(1);
        run_flat(0, -1, -1, -1, 6150, nwr, dc, nd, bb, pb);
        check_run("extreme", 0, 1, nwr, 2048, bb, pb);
    endtask

    task automatic test_start_ignored();
        int nwr, dc, nd, bb, pb;
        load_data(0);
        run_flat(0, 1, 500, 6145, 6150, nwr, dc, nd, bb, pb);
        check_run("ignored", 0, 0, nwr, 2048, bb, pb);
        n_checks++;
        if (nd != 1) begin
            n_fail++;
            $display("FAIL ignored_done_pulses: got %0d required 1", nd);
        end
    endtask

    task automatic test_back_to_back();
        int nwr, dc, nd, bb, pb;
        load_data(0);
        run_flat(0, -1, -1, 6146, 12300, nwr, dc, nd, bb, pb);
        check_run("back_to_back", 0, 0, nwr, 4096, bb, pb);
        n_checks++;
        if (nd != 2) begin
            n_fail++;
            $display("FAIL back_to_back_done_pulses: got %0d required 2", nd);
        end
    endtask

    task automatic test_reset_mid_run();
        int nwr, dc, nd, bb, pb;
        int   found = 0;
        int   quiet_bad = 0;
        load_data(0);
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        for (int c = 0; c < 1000 && found == 0; c++) begin
            @(negedge clk);
            if (cwr[0] === 1'b1 && caddr_wr[0] === 12'd100) found = 1;
        end
        n_checks++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL midrun_reach_wr100: got no write to 100 within 1000 cycles required one");
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy[0], done[0], crd[0], cwr[0], csel[0], caddr_rd[0], caddr_wr[0], cdata_wr[0]} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset_outputs: got busy=%b crd=%b cwr=%b csel=%b caddr_wr=%0d, required all zero",
                     busy[0], crd[0], cwr[0], csel[0], caddr_wr[0]);
        end
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (crd[0] !== 1'b0 || cwr[0] !== 1'b0 || busy[0] !== 1'b0) quiet_bad++;
        end
        n_checks++;
        if (quiet_bad != 0) begin
            n_fail++;
            $display("FAIL midrun_quiet_after_reset: got %0d active cycles required 0", quiet_bad);
        end
        run_flat(0, -1, -1, -1, 6150, nwr, dc, nd, bb, pb);
        check_run("midrun_rerun", 0, 0, nwr, 2048, bb, pb);
    endtask

    task automatic test_rd_lat2();
        int nwr, dc, nd, bb, pb;
        load_data(0);
        run_flat(1, -1, -1, -1, 8200, nwr, dc, nd, bb, pb);
        check_run("lat2", 1, 0, nwr, 2048, bb, pb);
        n_checks++;
        if (dc != 8193) begin
            n_fail++;
            $display("FAIL lat2_done_cycle: got %0d required 8193", dc);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        start    = '0;
        reset    = 1'b1;
        load_data(0);
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_basic();
        test_extreme();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_rd_lat2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
